// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and defaults for the ARM memory arbiter
// Purpose: return-owner encoding, grant bit positions, default sizing and the
//          starvation counter width helper used by arm_mem_arb and arm_mem_prio.
// Ports:   none (package).
package arm_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2,
    OWN_M    = 2'd3
  } owner_e;

  localparam int AW_DEF         = 14;
  localparam int STARVE_MAX_DEF = 4;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_D = 0;
  localparam int GNT_I = 1;
  localparam int GNT_M = 2;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arm_mem_prio.sv
// rtl/arm_mem_prio.sv - combinational priority / starvation selector
// Purpose: picks one of data, fetch, DMA each cycle. Normal order is
//          data > DMA > fetch; a fetch that has waited STARVE_MAX cycles wins.
// Ports:   i_d_vld, i_i_vld, i_m_vld  - qualified requests
//          i_starve_cnt               - consecutive denied fetch cycles
//          o_gnt                      - one-hot grant {M, I, D}
module arm_mem_prio
  import arm_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CW         = cnt_width(STARVE_MAX)
) (
  input  logic          i_d_vld,
  input  logic          i_i_vld,
  input  logic          i_m_vld,
  input  logic [CW-1:0] i_starve_cnt,
  output logic [2:0]    o_gnt
);

  localparam logic [CW-1:0] LP_STARVE_MAX = CW'(STARVE_MAX);

  always_comb begin
    o_gnt = '0;
    if (i_i_vld && (i_starve_cnt == LP_STARVE_MAX)) begin
      o_gnt[GNT_I] = 1'b1;
    end else if (i_d_vld) begin
      o_gnt[GNT_D] = 1'b1;
    end else if (i_m_vld) begin
      o_gnt[GNT_M] = 1'b1;
    end else if (i_i_vld) begin
      o_gnt[GNT_I] = 1'b1;
    end
  end

endmodule

// File: rtl/arm_mem_arb.sv
// rtl/arm_mem_arb.sv - single-port SRAM arbiter for ARM data, fetch and DMA
// Purpose: shares one synchronous SRAM between the core data port, the core
//          fetch port and a DMA requester; stalls the core via o_cpu_en and
//          flags out-of-range core addresses with one-cycle aborts.
// Ports:   i_clk, i_rst (async, active low)
//          core data : i_d_cen, i_d_wen, i_d_flag, i_d_addr, i_d_wdata,
//                      o_d_rdata, o_d_abort
//          core fetch: i_i_en, i_i_addr, o_i_data, o_i_abort
//          core stall: o_cpu_en
//          DMA       : i_m_req, i_m_we, i_m_addr, i_m_wdata, o_m_gnt,
//                      o_m_rvalid, o_m_rdata
//          SRAM      : o_s_cs, o_s_we, o_s_be, o_s_addr, o_s_wdata, i_s_rdata
module arm_mem_arb
  import arm_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_d_cen,
  input  logic          i_d_wen,
  input  logic [3:0]    i_d_flag,
  input  logic [31:0]   i_d_addr,
  input  logic [31:0]   i_d_wdata,
  output logic [31:0]   o_d_rdata,
  output logic          o_d_abort,
  input  logic          i_i_en,
  input  logic [31:0]   i_i_addr,
  output logic [31:0]   o_i_data,
  output logic          o_i_abort,
  output logic          o_cpu_en,
  input  logic          i_m_req,
  input  logic          i_m_we,
  input  logic [AW-1:0] i_m_addr,
  input  logic [31:0]   i_m_wdata,
  output logic          o_m_gnt,
  output logic          o_m_rvalid,
  output logic [31:0]   o_m_rdata,
  output logic          o_s_cs,
  output logic          o_s_we,
  output logic [3:0]    o_s_be,
  output logic [AW-1:0] o_s_addr,
  output logic [31:0]   o_s_wdata,
  input  logic [31:0]   i_s_rdata
);

  localparam int            CW            = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] LP_STARVE_MAX = CW'(STARVE_MAX);

  function automatic logic addr_ok(input logic [31:0] a);
    return (a >> (AW + 2)) == 32'd0;
  endfunction

  logic          w_d_req, w_i_req, w_d_ok, w_i_ok;
  logic          w_d_vld, w_i_vld, w_m_vld;
  logic [2:0]    w_gnt;
  logic          w_gnt_d, w_gnt_i, w_gnt_m;
  logic          w_stall;
  owner_e        w_own_nxt;
  logic [CW-1:0] w_starve_nxt;

  owner_e        r_own;
  logic [CW-1:0] r_starve;
  logic [31:0]   r_d_hold, r_i_hold, r_m_hold;
  logic          r_d_abort, r_i_abort, r_cpu_en;

  assign w_d_req = !i_d_cen;
  assign w_i_req = i_i_en;
  assign w_d_ok  = addr_ok(i_d_addr);
  assign w_i_ok  = addr_ok(i_i_addr);

  // Qualifying with i_rst keeps the SRAM idle while reset is asserted.
  assign w_d_vld = i_rst && w_d_req && w_d_ok;
  assign w_i_vld = i_rst && w_i_req && w_i_ok;
  assign w_m_vld = i_rst && i_m_req;

  arm_mem_prio #(
    .STARVE_MAX (STARVE_MAX),
    .CW         (CW)
  ) u_prio (
    .i_d_vld      (w_d_vld),
    .i_i_vld      (w_i_vld),
    .i_m_vld      (w_m_vld),
    .i_starve_cnt (r_starve),
    .o_gnt        (w_gnt)
  );

  assign w_gnt_d = w_gnt[GNT_D];
  assign w_gnt_i = w_gnt[GNT_I];
  assign w_gnt_m = w_gnt[GNT_M];

  always_comb begin
    o_s_cs    = w_gnt_d || w_gnt_i || w_gnt_m;
    o_s_we    = 1'b0;
    o_s_be    = 4'h0;
    o_s_addr  = '0;
    o_s_wdata = '0;
    if (w_gnt_d) begin
      o_s_we    = !i_d_wen;
      o_s_be    = i_d_flag;
      o_s_addr  = i_d_addr[AW+1:2];
      o_s_wdata = i_d_wdata;
    end else if (w_gnt_i) begin
      o_s_be    = 4'hF;
      o_s_addr  = i_i_addr[AW+1:2];
    end else if (w_gnt_m) begin
      o_s_we    = i_m_we;
      o_s_be    = 4'hF;
      o_s_addr  = i_m_addr;
      o_s_wdata = i_m_wdata;
    end
  end

  assign o_m_gnt = w_gnt_m;

  always_comb begin
    w_own_nxt = OWN_NONE;
    if (w_gnt_d && i_d_wen) begin
      w_own_nxt = OWN_D;
    end else if (w_gnt_i) begin
      w_own_nxt = OWN_I;
    end else if (w_gnt_m && !i_m_we) begin
      w_own_nxt = OWN_M;
    end
  end

  // Fetch is always a read, so any fetch request (granted, denied or aborted)
  // costs a stall. A data request stalls unless it is a granted write.
  assign w_stall = (w_d_req && !(w_gnt_d && !i_d_wen)) || w_i_req;

  always_comb begin
    w_starve_nxt = '0;
    if (w_i_vld && !w_gnt_i) begin
      w_starve_nxt = (r_starve == LP_STARVE_MAX) ? r_starve : r_starve + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_own     <= OWN_NONE;
      r_starve  <= '0;
      r_d_hold  <= '0;
      r_i_hold  <= '0;
      r_m_hold  <= '0;
      r_d_abort <= 1'b0;
      r_i_abort <= 1'b0;
      r_cpu_en  <= 1'b0;
    end else begin
      r_own     <= w_own_nxt;
      r_starve  <= w_starve_nxt;
      r_d_abort <= w_d_req && !w_d_ok;
      r_i_abort <= w_i_req && !w_i_ok;
      r_cpu_en  <= !w_stall;
      if (r_own == OWN_D) r_d_hold <= i_s_rdata;
      if (r_own == OWN_I) r_i_hold <= i_s_rdata;
      if (r_own == OWN_M) r_m_hold <= i_s_rdata;
    end
  end

  // The return cycle passes SRAM data straight through; otherwise each
  // return port keeps the last word it was given.
  assign o_d_rdata  = (r_own == OWN_D) ? i_s_rdata : r_d_hold;
  assign o_i_data   = (r_own == OWN_I) ? i_s_rdata : r_i_hold;
  assign o_m_rdata  = (r_own == OWN_M) ? i_s_rdata : r_m_hold;
  assign o_m_rvalid = (r_own == OWN_M);
  assign o_d_abort  = r_d_abort;
  assign o_i_abort  = r_i_abort;
  assign o_cpu_en   = r_cpu_en;

endmodule
